cbus_arbiter_rr: RTL

- N-to-1 arbiter for the shared CBus. Multiplexes NUM_CH cached/uncached bus requesters (I-side, D-side, and later extra ports such as a PTW or a second core) onto the single outgoing oreq/oresp pair.
- Extends the fixed two-input arbiter:
  - parametrised channel count;
  - selectable fixed-priority or round-robin policy;
  - transaction lock until the last beat;
  - per-channel completed-transaction counters for performance monitoring.

---
 rtl/cbus_arbiter_rr_pkg.sv | 31 +++
 rtl/cbus_arbiter_rr_rr_pick.sv | 37 +++
 rtl/cbus_arbiter_rr.sv | 108 ++++++++++
 3 files changed

// File: rtl/cbus_arbiter_rr_pkg.sv
// Shared CBus types plus the arbiter policy enum and FSM state type.
// Imported by the arbiter top and its picker sub-module.
package cbus_arbiter_rr_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } cbus_arb_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cbus_arbiter_rr_rr_pick.sv
// Combinational winner picker: fixed (lowest index) or round-robin
// starting after ptr_i. Ports: valid_i, ptr_i, mode_i -> win_o, any_o.
module rr_pick
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] valid_i,
  input  logic [IDX_W-1:0]  ptr_i,
  input  cbus_arb_mode_t    mode_i,
  output logic [IDX_W-1:0]  win_o,
  output logic              any_o
);

  int unsigned base;
  int unsigned idx;
  logic        found;

  // Scan NUM_CH candidates starting at base; fixed mode starts at 0.
  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    base  = (mode_i == ARB_RR) ? (32'(ptr_i) + 32'd1) : 32'd0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (base + k) % 32'(NUM_CH);
      if (!found && valid_i[IDX_W'(idx)]) begin
        win_o = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/cbus_arbiter_rr.sv
// N-to-1 CBus arbiter with fixed/round-robin policy, burst lock and
// saturating per-channel completion counters.
// Ports: clk, reset (async high), ireqs/iresps per channel,
// oreq/oresp downstream, grant_idx, busy, done_cnt.
module cbus_arbiter_rr
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = 1,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs [NUM_CH],
  output cbus_resp_t iresps [NUM_CH],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp,
  output logic [((NUM_CH > 2) ? $clog2(NUM_CH) : 1)-1:0] grant_idx,
  output logic       busy,
  output logic [CNT_W-1:0] done_cnt [NUM_CH]
);

  localparam int IDX_W =
    (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam cbus_arb_mode_t MODE =
    (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  logic [NUM_CH-1:0] valid_vec;
  logic [IDX_W-1:0]  win;
  logic              any_valid;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .valid_i (valid_vec),
    .ptr_i   (last_q),
    .mode_i  (MODE),
    .win_o   (win),
    .any_o   (any_valid)
  );

  // Grant held until the last ready beat; one IDLE cycle between grants.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    oreq    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      iresps[i] = '0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_BUSY;
          sel_d   = win;
        end
      end
      ST_BUSY: begin
        oreq          = ireqs[sel_q];
        iresps[sel_q] = oresp;
        if (oresp.ready && oresp.last) begin
          state_d = ST_IDLE;
          last_d  = sel_q;
          if (cnt_q[sel_q] != '1) begin
            cnt_d[sel_q] = cnt_q[sel_q] + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= IDX_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign grant_idx = sel_q;
  assign done_cnt  = cnt_q;

endmodule
